fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares one 8-bit FIFO write port between NREQ requesters. Each requester streams bytes with a valid/ready/last handshake. A grant is held for a whole burst, up to MAX_BURST beats. The arbiter drives the FIFO's wen/wdata and uses the FIFO occupancy count to guarantee the FIFO never overflows.

---
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle for fifo_wr_arbiter.
// slave = arbiter side, master = requesters/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NREQ     = 4,
    parameter int MAX_DATA = 256
);
    localparam int CW = $clog2(MAX_DATA) + 1;

    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [CW-1:0]     fifo_count;
    logic              fifo_wen;
    logic [7:0]        fifo_wdata;
    logic [NREQ-1:0]   grant;
    logic              busy;

    modport slave (
        input  req_valid, req_data, req_last, fifo_count,
        output req_ready, fifo_wen, fifo_wdata, grant, busy
    );

    modport master (
        output req_valid, req_data, req_last, fifo_count,
        input  req_ready, fifo_wen, fifo_wdata, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port.
// Grants are held per burst and capped at MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_DATA  = 256,
    parameter int MAX_BURST = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    fifo_wr_arbiter_if.slave      bus
);
    localparam int AW = $clog2(MAX_DATA);
    localparam int SW = AW + 2;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_grant;
    logic [PW-1:0]   r_owner;
    logic [PW-1:0]   r_ptr;
    logic [BW-1:0]   r_beat_cnt;
    logic            r_wen;
    logic [7:0]      r_wdata;

    logic [SW-1:0]   w_sum;
    logic            w_space_ok;
    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic            w_own_valid;
    logic            w_own_last;
    logic [7:0]      w_own_data;
    logic            w_accept;
    logic            w_release;
    logic [NREQ-1:0] w_ready;

    function automatic logic [PW-1:0] rr_idx(
        input logic [PW-1:0] p,
        input int            k
    );
        int s;
        s = (int'(p) + k) % NREQ;
        return PW'(s);
    endfunction

    // The write already in flight counts against free space.
    assign w_sum      = {1'b0, bus.fifo_count} + SW'(r_wen);
    assign w_space_ok = (w_sum < SW'(MAX_DATA));

    // Rotating priority search starting just after the last owner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && bus.req_valid[rr_idx(r_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = rr_idx(r_ptr, k);
            end
        end
    end

    // Mux the current owner's handshake and byte.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == PW'(i)) begin
                w_own_valid = bus.req_valid[i];
                w_own_last  = bus.req_last[i];
                w_own_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    assign w_accept  = (r_state == S_BURST) && w_own_valid && w_space_ok;
    assign w_release = w_accept &&
                       (w_own_last || (r_beat_cnt == BW'(MAX_BURST - 1)));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and ready decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) w_state_nxt = S_BURST;
            end
            S_BURST: begin
                w_ready[r_owner] = w_space_ok;
                if (w_release) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant, pointer, beat counter and registered FIFO write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant    <= '0;
            r_owner    <= '0;
            r_ptr      <= PW'(NREQ - 1);
            r_beat_cnt <= '0;
            r_wen      <= 1'b0;
            r_wdata    <= '0;
        end else begin
            r_wen <= w_accept;
            if (w_accept) begin
                r_wdata    <= w_own_data;
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if ((r_state == S_IDLE) && w_found) begin
                r_grant    <= {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
                r_owner    <= w_winner;
                r_beat_cnt <= '0;
            end
            if (w_release) begin
                r_ptr   <= r_owner;
                r_grant <= '0;
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.fifo_wen   = r_wen;
    assign bus.fifo_wdata = r_wdata;
    assign bus.grant      = r_grant;
    assign bus.busy       = (r_state == S_BURST);

endmodule
